// File: rtl/cmd_issuer.sv
// Command issuer: FIFO-buffered 32-bit commands sent as one-cycle enable pulses
// with a GAP-cycle hold-off. Optional LED completion monitor via CMD_ISSUER_ACK_EN.
module cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_value,
  output logic        enable,
  output logic [31:0] value,
  output logic        busy,
  output logic [15:0] issued,
  input  logic [7:0]  led_in,
  output logic        ack,
  output logic [15:0] ack_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [3:0]      gap_cnt;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign req_ready = !full;
  assign push      = req_valid && !full;
  // A pop is the issue decision: IDLE with data, or HOLD at gap expiry with data.
  assign pop       = !empty && ((state == IDLE) || (state == HOLD && gap_cnt == 4'd0));
  assign busy      = !empty || (state != IDLE);

  // NOTE: the storage array has no reset; only pointers and occupancy define validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= req_value;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      enable  <= 1'b0;
      value   <= '0;
      issued  <= '0;
      gap_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      enable <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (pop) begin
        state  <= ISSUE;
        enable <= 1'b1;
        value  <= mem[rd_ptr];
        issued <= issued + 16'd1;
        rd_ptr <= rd_ptr + 1'b1;
      end else begin
        case (state)
          ISSUE: begin
            state   <= HOLD;
            gap_cnt <= 4'(GAP - 1);
          end
          HOLD: begin
            if (gap_cnt == 4'd0) state <= IDLE;
            else                 gap_cnt <= gap_cnt - 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CMD_ISSUER_ACK_EN
  logic led_q;
  logic unused_led;
  assign unused_led = ^led_in[6:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led_q     <= 1'b0;
      ack       <= 1'b0;
      ack_count <= '0;
    end else begin
      led_q <= led_in[7];
      ack   <= led_in[7] && !led_q;
      if (led_in[7] && !led_q) ack_count <= ack_count + 16'd1;
    end
  end
`else
  logic unused_led;
  assign unused_led = ^led_in;
  assign ack        = 1'b0;
  assign ack_count  = '0;
`endif

endmodule

// File: tb/tb_cmd_issuer.sv
// Self-checking bench for cmd_issuer: scoreboard of pushed values checked
// against each enable pulse, plus latency, spacing, reset, wrap and ack checks.
module tb_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_value = '0;
  logic        enable;
  logic [31:0] value;
  logic        busy;
  logic [15:0] issued;
  logic [7:0]  led_in = '0;
  logic        ack;
  logic [15:0] ack_count;

  cmd_issuer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_value(req_value),
    .enable(enable), .value(value), .busy(busy), .issued(issued),
    .led_in(led_in), .ack(ack), .ack_count(ack_count)
  );

  always #5 CLK = ~CLK;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] sb [$];
  int          pulse_cyc [$];
  logic [15:0] exp_issued = '0;
  logic        prev_en = 1'b0;
  logic        saw_full = 1'b0;
  int          last_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor: every enable pulse must match the oldest accepted value.
  always @(negedge CLK) begin
    if (RST_N && enable) begin
      check("pulse_not_consecutive", {31'd0, prev_en}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {31'd0, enable}, 32'd0);
      end else begin
        check("pulse_value", value, sb.pop_front());
        exp_issued = exp_issued + 16'd1;
        check("issued_on_pulse", {16'd0, issued}, {16'd0, exp_issued});
      end
      pulse_cyc.push_back(cyc);
    end
    if (RST_N && !req_ready) saw_full = 1'b1;
    prev_en = enable;
  end

  task automatic push(input logic [31:0] v);
    int n = 0;
    @(negedge CLK);
    req_valid = 1'b1;
    req_value = v;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      check("push_timeout", {31'd0, req_ready}, 32'd1);
    end else begin
      sb.push_back(v);
      @(posedge CLK);
      #1;
      last_acc = cyc;
    end
  endtask

  task automatic stop_push();
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("drain_in_time", {31'd0, n < 200}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    sb.delete();
    pulse_cyc.delete();
    exp_issued = '0;
    RST_N = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack;

    // Reset values
    do_reset();
    @(negedge CLK);
    check("rst_enable", {31'd0, enable}, 32'd0);
    check("rst_value", value, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_issued", {16'd0, issued}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_ack_count", {16'd0, ack_count}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Single push: pulse one edge after acceptance, busy clears after GAP+1 more edges
    push(32'hDEADBEEF);
    req_valid = 1'b0;
    repeat (GAP + 2) @(negedge CLK);
    check("single_busy_before_idle", {31'd0, busy}, 32'd1);
    @(negedge CLK);
    check("single_busy_cleared", {31'd0, busy}, 32'd0);
    check("single_pulse_count", pulse_cyc.size(), 32'd1);
    if (pulse_cyc.size() == 1)
      check("single_latency", pulse_cyc[0] - last_acc, 32'd1);
    check("single_issued", {16'd0, issued}, 32'd1);

    // Back-to-back pushes overflow the FIFO; pulses spaced GAP+1 apart
    do_reset();
    saw_full = 1'b0;
    for (int i = 1; i <= 6; i++) push(32'(i));
    stop_push();
    wait_drain();
    check("b2b_req_ready_dropped", {31'd0, saw_full}, 32'd1);
    check("b2b_pulse_count", pulse_cyc.size(), 32'd6);
    for (int i = 1; i < pulse_cyc.size(); i++)
      check($sformatf("b2b_spacing_%0d", i), pulse_cyc[i] - pulse_cyc[i-1], GAP + 1);
    check("b2b_issued", {16'd0, issued}, 32'd6);
    check("b2b_ready_after", {31'd0, req_ready}, 32'd1);

    // Reset during HOLD with three entries still queued
    do_reset();
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    RST_N = 1'b0;
    req_valid = 1'b0;
    #1;
    check("midrst_enable", {31'd0, enable}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge CLK);
    sb.delete();
    pulse_cyc.delete();
    exp_issued = '0;
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    check("midrst_no_pulses", pulse_cyc.size(), 32'd0);
    check("midrst_issued", {16'd0, issued}, 32'd0);
    check("midrst_busy_after", {31'd0, busy}, 32'd0);

    // Issued counter wrap
    @(negedge CLK);
    force dut.issued = 16'hFFFF;
    @(negedge CLK);
    release dut.issued;
    exp_issued = 16'hFFFF;
    push(32'h1234_5678);
    stop_push();
    wait_drain();
    check("wrap_issued", {16'd0, issued}, 32'd0);

    // Ack monitor on led_in[7]
    @(negedge CLK);
    led_in = 8'h00;
    repeat (2) @(negedge CLK);
    led_in = 8'h80;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (ack) n_ack++;
    end
`ifdef CMD_ISSUER_ACK_EN
    check("ack_pulses", n_ack, 32'd1);
    check("ack_count", {16'd0, ack_count}, 32'd1);
`else
    check("ack_pulses", n_ack, 32'd0);
    check("ack_count", {16'd0, ack_count}, 32'd0);
`endif
    led_in = 8'h00;
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
